spi_master_tx: RTL and testbench

SPI transmit shifter of the SPI master. Pops 32-bit words from the TX FIFO over a valid/ready handshake and shifts them MSB-first onto the serial data outputs, one step per transmit-edge strobe from the SPI clock generator. Standard mode drives one bit per step on `sdo0_o`; quad mode drives one nibble per step on `sdo3_o`..`sdo0_o`. Enables the SPI clock only while it has data to shift.

---
 rtl/spi_master_tx_if.sv | 19 +
 rtl/spi_master_tx.sv | 122 ++++++++++++
 tb/tb_spi_master_tx.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_tx_if.sv
// Valid/ready word stream between the TX FIFO (master) and the SPI transmit
// shifter (slave).
interface spi_master_tx_if;
    logic [31:0] data;
    logic        valid;
    logic        ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/spi_master_tx.sv
// SPI master transmit shifter: pops 32-bit words from the TX FIFO and shifts
// them MSB-first on sdo0 (standard) or sdo3..sdo0 (quad), one step per tx edge.
module spi_master_tx #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 tx_edge_i,
    input  logic                 en_quad_in_i,
    input  logic [CNT_WIDTH-1:0] counter_in_i,
    input  logic                 counter_in_upd_i,
    spi_master_tx_if.slave       fifo,
    output logic                 clk_en_o,
    output logic                 tx_done_o,
    output logic                 sdo0_o,
    output logic                 sdo1_o,
    output logic                 sdo2_o,
    output logic                 sdo3_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRANSMIT,
        ST_WAIT
    } state_e;

    state_e               state_q;
    logic [31:0]          data_int_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] trgt_q;
    logic                 quad_q;
    logic                 done_q;

    logic [CNT_WIDTH-1:0] cnt_d;
    logic [31:0]          data_shift;
    logic                 last_step;
    logic                 word_end;
    logic                 pop;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        cnt_d      = cnt_q + CNT_WIDTH'(1);
        last_step  = (cnt_d == trgt_q);
        word_end   = quad_q ? (cnt_d[2:0] == 3'd0) : (cnt_d[4:0] == 5'd0);
        data_shift = quad_q ? {data_int_q[27:0], 4'b0000} : {data_int_q[30:0], 1'b0};
        pop        = 1'b0;
        case (state_q)
            ST_IDLE:     pop = en_i && fifo.valid && (trgt_q != '0);
            // The reload rides on the W-th edge so a full FIFO streams without a bubble.
            ST_TRANSMIT: pop = tx_edge_i && !last_step && word_end && fifo.valid;
            ST_WAIT:     pop = fifo.valid;
            default:     pop = 1'b0;
        endcase
    end

    assign fifo.ready = pop;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            data_int_q <= '0;
            cnt_q      <= '0;
            trgt_q     <= '0;
            quad_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (counter_in_upd_i) begin
                        // Quad counts nibble steps, so the two LSBs of the bit count drop.
                        trgt_q <= en_quad_in_i ? (counter_in_i >> 2) : counter_in_i;
                        quad_q <= en_quad_in_i;
                    end
                    if (pop) begin
                        data_int_q <= fifo.data;
                        cnt_q      <= '0;
                        state_q    <= ST_TRANSMIT;
                    end else if (en_i && (trgt_q == '0)) begin
                        done_q <= 1'b1;
                    end
                end
                ST_TRANSMIT: begin
                    if (tx_edge_i) begin
                        cnt_q <= cnt_d;
                        if (last_step) begin
                            data_int_q <= '0;
                            done_q     <= 1'b1;
                            state_q    <= ST_IDLE;
                        end else if (pop) begin
                            data_int_q <= fifo.data;
                        end else begin
                            data_int_q <= data_shift;
                            if (word_end) begin
                                state_q <= ST_WAIT;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (pop) begin
                        data_int_q <= fifo.data;
                        state_q    <= ST_TRANSMIT;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign clk_en_o  = (state_q == ST_TRANSMIT);
    assign tx_done_o = done_q;
    assign sdo0_o    = quad_q ? data_int_q[28] : data_int_q[31];
    assign sdo1_o    = quad_q & data_int_q[29];
    assign sdo2_o    = quad_q & data_int_q[30];
    assign sdo3_o    = quad_q & data_int_q[31];

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: a per-cycle vector table for quad and
// zero-length transfers, plus hand-written standard-mode streaming sequences.
module tb_spi_master_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        tx_edge;
    logic        quad_in;
    logic [15:0] cnt_in;
    logic        cnt_upd;
    logic        clk_en;
    logic        done;
    logic        sdo0, sdo1, sdo2, sdo3;
    logic [3:0]  sdo;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_pops = 0;

    spi_master_tx_if fifo ();

    spi_master_tx #(.CNT_WIDTH(16)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .en_i             (en),
        .tx_edge_i        (tx_edge),
        .en_quad_in_i     (quad_in),
        .counter_in_i     (cnt_in),
        .counter_in_upd_i (cnt_upd),
        .fifo             (fifo),
        .clk_en_o         (clk_en),
        .tx_done_o        (done),
        .sdo0_o           (sdo0),
        .sdo1_o           (sdo1),
        .sdo2_o           (sdo2),
        .sdo3_o           (sdo3)
    );

    assign sdo = {sdo3, sdo2, sdo1, sdo0};

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        en;
        logic        txe;
        logic        upd;
        logic        quad;
        logic [15:0] cnt;
        logic        valid;
        logic [31:0] data;
        logic        exp_ready;
        logic        exp_clk_en;
        logic        exp_done;
        logic [3:0]  exp_sdo;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(logic e, logic t, logic u, logic q, logic [15:0] c,
                                logic v, logic [31:0] d,
                                logic xr, logic xc, logic xd, logic [3:0] xs);
        vec_t r;
        r.en = e; r.txe = t; r.upd = u; r.quad = q; r.cnt = c;
        r.valid = v; r.data = d;
        r.exp_ready = xr; r.exp_clk_en = xc; r.exp_done = xd; r.exp_sdo = xs;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
    task automatic sample();
        @(negedge clk);
        if (fifo.ready === 1'b1 && fifo.valid === 1'b1) n_pops++;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] n, input logic q);
        cnt_upd = 1'b1; cnt_in = n; quad_in = q;
        adv();
        cnt_upd = 1'b0; quad_in = 1'b0; cnt_in = '0;
    endtask

    task automatic start(input string tag, input logic [31:0] word);
        en = 1'b1; fifo.valid = 1'b1; fifo.data = word;
        sample();
        check($sformatf("%s start ready", tag), fifo.ready, 1'b1);
        check($sformatf("%s start clk_en", tag), clk_en, 1'b0);
        adv();
        en = 1'b0;
    endtask

    task automatic edge_cycle(input string tag, input logic x_sdo0, input logic x_ready,
                              input logic x_clk_en);
        tx_edge = 1'b1;
        sample();
        check($sformatf("%s sdo0", tag), sdo0, x_sdo0);
        check($sformatf("%s ready", tag), fifo.ready, x_ready);
        check($sformatf("%s clk_en", tag), clk_en, x_clk_en);
        check($sformatf("%s done", tag), done, 1'b0);
        adv();
        tx_edge = 1'b0;
    endtask

    task automatic quiet_cycle(input string tag, input logic x_sdo0, input logic x_clk_en);
        tx_edge = 1'b0;
        sample();
        check($sformatf("%s sdo0", tag), sdo0, x_sdo0);
        check($sformatf("%s clk_en", tag), clk_en, x_clk_en);
        check($sformatf("%s ready", tag), fifo.ready, 1'b0);
        adv();
    endtask

    task automatic done_seq(input string tag);
        sample();
        check($sformatf("%s done pulse", tag), done, 1'b1);
        check($sformatf("%s clk_en at done", tag), clk_en, 1'b0);
        adv();
        sample();
        check($sformatf("%s done cleared", tag), done, 1'b0);
        adv();
    endtask

    initial begin
        logic [31:0] w;
        int          pops0;

        rst_n = 1'b0; en = 1'b0; tx_edge = 1'b0; quad_in = 1'b0;
        cnt_in = '0; cnt_upd = 1'b0; fifo.valid = 1'b0; fifo.data = '0;

        // Quad 16-bit transfer of 0x1234ABCD, then a zero-length transfer.
        //                en  txe upd quad cnt  valid data          rdy clk done sdo
        vecs[0]  = mk(1'b0,1'b0,1'b1,1'b1,16'd16,1'b0,32'h0,        1'b0,1'b0,1'b0,4'h0);
        vecs[1]  = mk(1'b1,1'b0,1'b0,1'b0,16'd0, 1'b1,32'h1234ABCD, 1'b1,1'b0,1'b0,4'h0);
        vecs[2]  = mk(1'b0,1'b0,1'b0,1'b0,16'd0, 1'b0,32'h0,        1'b0,1'b1,1'b0,4'h1);
        vecs[3]  = mk(1'b0,1'b1,1'b0,1'b0,16'd0, 1'b1,32'hFFFFFFFF, 1'b0,1'b1,1'b0,4'h1);
        vecs[4]  = mk(1'b0,1'b1,1'b0,1'b0,16'd0, 1'b0,32'h0,        1'b0,1'b1,1'b0,4'h2);
        vecs[5]  = mk(1'b0,1'b0,1'b0,1'b0,16'd0, 1'b0,32'h0,        1'b0,1'b1,1'b0,4'h3);
        vecs[6]  = mk(1'b0,1'b1,1'b0,1'b0,16'd0, 1'b0,32'h0,        1'b0,1'b1,1'b0,4'h3);
        vecs[7]  = mk(1'b0,1'b1,1'b0,1'b0,16'd0, 1'b1,32'h55555555, 1'b0,1'b1,1'b0,4'h4);
        vecs[8]  = mk(1'b0,1'b0,1'b0,1'b0,16'd0, 1'b1,32'h55555555, 1'b0,1'b0,1'b1,4'h0);
        vecs[9]  = mk(1'b0,1'b0,1'b0,1'b0,16'd0, 1'b0,32'h0,        1'b0,1'b0,1'b0,4'h0);
        vecs[10] = mk(1'b0,1'b0,1'b1,1'b0,16'd0, 1'b0,32'h0,        1'b0,1'b0,1'b0,4'h0);
        vecs[11] = mk(1'b1,1'b0,1'b0,1'b0,16'd0, 1'b1,32'h89ABCDEF, 1'b0,1'b0,1'b0,4'h0);
        vecs[12] = mk(1'b0,1'b0,1'b0,1'b0,16'd0, 1'b1,32'h89ABCDEF, 1'b0,1'b0,1'b1,4'h0);
        vecs[13] = mk(1'b0,1'b0,1'b0,1'b0,16'd0, 1'b0,32'h0,        1'b0,1'b0,1'b0,4'h0);

        sample();
        check("in-reset clk_en", clk_en, 1'b0);
        check("in-reset sdo", sdo, 4'h0);
        adv();
        rst_n = 1'b1;

        pops0 = n_pops;
        for (int i = 0; i < 14; i++) begin
            en = vecs[i].en; tx_edge = vecs[i].txe; cnt_upd = vecs[i].upd;
            quad_in = vecs[i].quad; cnt_in = vecs[i].cnt;
            fifo.valid = vecs[i].valid; fifo.data = vecs[i].data;
            sample();
            check($sformatf("vec%0d ready", i), fifo.ready, vecs[i].exp_ready);
            check($sformatf("vec%0d clk_en", i), clk_en, vecs[i].exp_clk_en);
            check($sformatf("vec%0d done", i), done, vecs[i].exp_done);
            check($sformatf("vec%0d sdo", i), sdo, vecs[i].exp_sdo);
            adv();
        end
        check("table pops", n_pops - pops0, 1);
        en = 1'b0; tx_edge = 1'b0; cnt_upd = 1'b0; quad_in = 1'b0; cnt_in = '0;
        fifo.valid = 1'b0;

        // Std 8 bits of 0xA5000000, one edge every 4 cycles; a second word stays
        // available throughout and must not be popped.
        pops0 = n_pops;
        w = 32'hA5000000;
        load(16'd8, 1'b0);
        start("std8", w);
        fifo.data = 32'h12345678;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 3; k++) quiet_cycle($sformatf("std8 b%0d", i), w[31-i], 1'b1);
            edge_cycle($sformatf("std8 e%0d", i), w[31-i], 1'b0, 1'b1);
        end
        done_seq("std8");
        fifo.valid = 1'b0;
        check("std8 pops", n_pops - pops0, 1);

        // Std 64 bits: all-ones word then all-zeros word, reload on the 32nd edge.
        pops0 = n_pops;
        load(16'd64, 1'b0);
        start("std64", 32'hFFFFFFFF);
        fifo.data = 32'h00000000;
        for (int i = 0; i < 64; i++) begin
            edge_cycle($sformatf("std64 e%0d", i), (i < 32), (i == 31), 1'b1);
            if (i == 31) fifo.valid = 1'b0;
        end
        done_seq("std64");
        check("std64 pops", n_pops - pops0, 2);

        // Std 40 bits with the second word arriving late: edges during WAIT are ignored.
        pops0 = n_pops;
        w = 32'hDEADBEEF;
        load(16'd40, 1'b0);
        start("std40", w);
        fifo.valid = 1'b0;
        for (int i = 0; i < 32; i++) edge_cycle($sformatf("std40 e%0d", i), w[31-i], 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) edge_cycle($sformatf("std40 stall%0d", i), 1'b0, 1'b0, 1'b0);
        w = 32'hC3000000;
        fifo.valid = 1'b1; fifo.data = w;
        sample();
        check("std40 resume ready", fifo.ready, 1'b1);
        check("std40 resume clk_en", clk_en, 1'b0);
        adv();
        fifo.valid = 1'b0;
        for (int i = 0; i < 8; i++) edge_cycle($sformatf("std40 r%0d", i), w[31-i], 1'b0, 1'b1);
        done_seq("std40");
        check("std40 pops", n_pops - pops0, 2);

        // Asynchronous reset after 10 bits of a 32-bit transfer, then a fresh transfer.
        w = 32'hF0F0F0F0;
        load(16'd32, 1'b0);
        start("rst", w);
        for (int i = 0; i < 10; i++) edge_cycle($sformatf("rst e%0d", i), w[31-i], 1'b0, 1'b1);
        en = 1'b1; fifo.valid = 1'b1; fifo.data = 32'hFFFFFFFF;
        rst_n = 1'b0;
        #1;
        check("rst clk_en", clk_en, 1'b0);
        check("rst sdo", sdo, 4'h0);
        check("rst done", done, 1'b0);
        check("rst ready", fifo.ready, 1'b0);
        adv();
        rst_n = 1'b1; en = 1'b0; fifo.valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            check($sformatf("post-rst done %0d", i), done, 1'b0);
            check($sformatf("post-rst clk_en %0d", i), clk_en, 1'b0);
            adv();
        end
        pops0 = n_pops;
        w = 32'h5A000000;
        load(16'd8, 1'b0);
        start("fresh", w);
        fifo.valid = 1'b0;
        for (int i = 0; i < 8; i++) edge_cycle($sformatf("fresh e%0d", i), w[31-i], 1'b0, 1'b1);
        done_seq("fresh");
        check("fresh pops", n_pops - pops0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
